keyboard_event_queue: RTL and testbench

- Sits directly downstream of the keyboard driver and consumes its translated keycode and key_status outputs.
- Tracks Shift modifier state.
- Turns each completed key release into a 9-bit event {shift, keycode}.
- Buffers events in a first-word-fall-through FIFO so the CPU I/O port can pop them at its own pace, with sticky overflow reporting.

---
 rtl/keyboard_event_queue.sv | 106 ++++++++++
 tb/tb_keyboard_event_queue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_event_queue.sv
// Keyboard event queue: tracks Shift, turns key releases into {shift, keycode}
// events and buffers them in a first-word-fall-through FIFO with sticky overflow.
module keyboard_event_queue #(
  parameter int         DEPTH          = 16,
  parameter logic [7:0] SHIFT_L_CODE   = 8'h80,
  parameter logic [7:0] SHIFT_R_CODE   = 8'h81,
  parameter bit         PUSH_MODIFIERS = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               keycode,
  input  logic [7:0]               key_status,
  input  logic                     rd_en,
  input  logic                     clear_overflow,
  output logic [8:0]               rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     shift_held,
  output logic                     overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [8:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          break_d_reg;
  logic          shift_held_reg;
  logic          overflow_reg;

  logic is_break, break_pulse, is_shift, push_edge, push_req;
  logic full, empty, pop, push_accept, push_drop;

  logic unused_status;
  assign unused_status = &{1'b0, key_status[7:2]};

  assign is_break    = key_status[0];
  assign break_pulse = key_status[1];
  assign is_shift    = (keycode == SHIFT_L_CODE) || (keycode == SHIFT_R_CODE);

  // A stretched break pulse must produce exactly one event, so only its rising edge counts.
  assign push_edge   = break_pulse && !break_d_reg;
  assign push_req    = push_edge && (!is_shift || PUSH_MODIFIERS);

  assign empty       = (count_reg == '0);
  assign full        = (count_reg == CW'(DEPTH));
  assign pop         = rd_en && !empty;
  // When full, a simultaneous pop frees the slot the push needs.
  assign push_accept = push_req && (!full || pop);
  assign push_drop   = push_req && full && !pop;

  always_comb begin
    count_next = count_reg;
    case ({push_accept, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage is deliberately not reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push_accept) begin
      mem[wr_ptr_reg] <= {shift_held_reg, keycode};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      break_d_reg    <= 1'b0;
      shift_held_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      break_d_reg <= break_pulse;
      count_reg   <= count_next;
      if (push_accept) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      if (is_shift && !is_break) begin
        shift_held_reg <= 1'b1;
      end else if (is_shift && break_pulse) begin
        shift_held_reg <= 1'b0;
      end
      // Dropping an event wins over a same-cycle clear.
      if (push_drop) begin
        overflow_reg <= 1'b1;
      end else if (clear_overflow) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  assign rd_valid   = !empty;
  assign rd_data    = empty ? 9'h000 : mem[rd_ptr_reg];
  assign count      = count_reg;
  assign shift_held = shift_held_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_keyboard_event_queue.sv
// Scoreboard bench for keyboard_event_queue: expected events are queued at push
// time and compared against the FIFO head when popped.
module tb_keyboard_event_queue;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] keycode;
  logic [7:0] key_status;
  logic       rd_en;
  logic       clear_overflow;
  logic [8:0] rd_data;
  logic       rd_valid;
  logic [4:0] count;
  logic       shift_held;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] sb_q[$];
  logic       shift_exp;
  logic       ovf_exp;

  keyboard_event_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .keycode        (keycode),
    .key_status     (key_status),
    .rd_en          (rd_en),
    .clear_overflow (clear_overflow),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .count          (count),
    .shift_held     (shift_held),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Release one key (optionally with a same-cycle pop) and update the scoreboard.
  task automatic release_key(input logic [7:0] kc, input bit with_pop);
    bit is_shift;
    bit popped;
    logic [8:0] exp_head;
    is_shift = (kc == 8'h80) || (kc == 8'h81);
    popped   = with_pop && (sb_q.size() > 0);
    if (popped) begin
      exp_head = sb_q.pop_front();
      n_checks++;
      if (rd_data !== exp_head) begin
        n_fail++;
        $display("FAIL release_pop_head: got %h expected %h", rd_data, exp_head);
      end
    end
    if (!is_shift) begin
      if (sb_q.size() < DEPTH) sb_q.push_back({shift_exp, kc});
      else ovf_exp = 1'b1;
    end else begin
      shift_exp = 1'b0;
    end
    keycode    = kc;
    key_status = 8'h03;
    rd_en      = with_pop;
    step();
    key_status = 8'h00;
    keycode    = 8'h00;
    rd_en      = 1'b0;
    n_checks++;
    if (count !== 5'(sb_q.size())) begin
      n_fail++;
      $display("FAIL release_count kc=%h: got %0d expected %0d", kc, count, sb_q.size());
    end
    $display("release kc=%h pop=%0d count=%0d", kc, with_pop, count);
    step();
  endtask

  task automatic pop_check();
    logic [8:0] exp_head;
    exp_head = sb_q.pop_front();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp_head) begin
      n_fail++;
      $display("FAIL pop_head: got valid=%b data=%h expected valid=1 data=%h",
               rd_valid, rd_data, exp_head);
    end
    $display("pop data=%h", rd_data);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    n_checks++;
    if (rd_valid !== 1'b0 || count !== 5'd0 || rd_data !== 9'h000) begin
      n_fail++;
      $display("FAIL %s: got valid=%b count=%0d data=%h expected 0/0/000",
               tag, rd_valid, count, rd_data);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; keycode = 8'h00; key_status = 8'h00;
    rd_en = 1'b0; clear_overflow = 1'b0;
    shift_exp = 1'b0; ovf_exp = 1'b0;
    repeat (3) step();
    check_empty("reset_during");
    n_checks++;
    if (shift_held !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got shift=%b ovf=%b expected 0/0", shift_held, overflow);
    end
    rst_n = 1'b1;
    step();
    check_empty("reset_after");
  endtask

  task automatic test_single();
    release_key(8'h1C, 1'b0);
    n_checks++;
    if (rd_data !== 9'h01C || rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_data: got %h expected 01c", rd_data);
    end
    pop_check();
    check_empty("single_after_pop");
  endtask

  task automatic test_shift();
    keycode = 8'h80; key_status = 8'h00;
    step();
    keycode = 8'h00;
    shift_exp = 1'b1;
    n_checks++;
    if (shift_held !== 1'b1) begin
      n_fail++;
      $display("FAIL shift_make: got %b expected 1", shift_held);
    end
    release_key(8'h1C, 1'b0);
    n_checks++;
    if (rd_data !== 9'h11C) begin
      n_fail++;
      $display("FAIL shift_event: got %h expected 11c", rd_data);
    end
    release_key(8'h80, 1'b0);
    n_checks++;
    if (shift_held !== 1'b0) begin
      n_fail++;
      $display("FAIL shift_release: got %b expected 0", shift_held);
    end
    pop_check();
    check_empty("shift_no_modifier_event");
  endtask

  task automatic test_stretch();
    keycode = 8'h2A; key_status = 8'h03;
    sb_q.push_back({shift_exp, 8'h2A});
    repeat (4) step();
    key_status = 8'h00; keycode = 8'h00;
    step();
    n_checks++;
    if (count !== 5'd1) begin
      n_fail++;
      $display("FAIL stretch_count: got %0d expected 1", count);
    end
    pop_check();
    check_empty("stretch_after_pop");
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 17; i++) release_key(8'(i), 1'b0);
    n_checks++;
    if (count !== 5'd16 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_set: got count=%0d ovf=%b expected 16/1", count, overflow);
    end
    for (int i = 0; i < 16; i++) pop_check();
    check_empty("overflow_drained");
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    ovf_exp = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_clear: got %b expected 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) release_key(8'h30 + 8'(i), 1'b0);
    release_key(8'h22, 1'b1);
    n_checks++;
    if (count !== 5'd16 || overflow !== 1'b0 || rd_data !== 9'h031) begin
      n_fail++;
      $display("FAIL full_push_pop: got count=%0d ovf=%b head=%h expected 16/0/031",
               count, overflow, rd_data);
    end
    for (int i = 0; i < 16; i++) pop_check();
    check_empty("full_push_pop_drained");
  endtask

  task automatic test_back_to_back();
    // Push and pop into an empty FIFO: the pop is ignored.
    release_key(8'h45, 1'b1);
    n_checks++;
    if (count !== 5'd1 || rd_data !== 9'h045) begin
      n_fail++;
      $display("FAIL empty_push_pop: got count=%0d head=%h expected 1/045", count, rd_data);
    end
    pop_check();
    check_empty("empty_push_pop_after");
  endtask

  task automatic test_mid_reset();
    keycode = 8'h81; key_status = 8'h00;
    step();
    keycode = 8'h00;
    shift_exp = 1'b1;
    for (int i = 0; i < 5; i++) release_key(8'h50 + 8'(i), 1'b0);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    shift_exp = 1'b0;
    check_empty("mid_reset_async");
    n_checks++;
    if (shift_held !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_shift: got %b expected 0", shift_held);
    end
    step();
    rst_n = 1'b1;
    step();
    release_key(8'h66, 1'b0);
    n_checks++;
    if (count !== 5'd1 || rd_data !== 9'h066) begin
      n_fail++;
      $display("FAIL mid_reset_next: got count=%0d head=%h expected 1/066", count, rd_data);
    end
    pop_check();
    check_empty("mid_reset_drained");
  endtask

  initial begin
    test_reset();
    test_single();
    test_shift();
    test_stretch();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
